// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: registers the writeback mux candidates, formats load data and stalls
// upstream while a load waits on late memory data. Optional check: MEM_WB_MISALIGN_CHK_EN.
module mem_wb_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            in_reg_write,
  input  logic [RD_W-1:0] in_rd,
  input  logic [1:0]      in_wb_sel,
  input  logic            in_is_load,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_rvalid,
  output logic            stall_o,
`ifdef MEM_WB_MISALIGN_CHK_EN
  output logic            wb_misalign,
`endif
  output logic            wb_valid,
  output logic            wb_reg_write,
  output logic [RD_W-1:0] wb_rd,
  output logic [1:0]      wb_sel,
  output logic [XLEN-1:0] wb_i0,
  output logic [XLEN-1:0] wb_i1,
  output logic [XLEN-1:0] wb_i2,
  output logic [XLEN-1:0] wb_i3
);

  typedef enum logic [0:0] {StRun, StWait} state_e;
  state_e state_q, state_d;

  logic [RD_W-1:0] hold_rd_q;
  logic            hold_rw_q;
  logic [1:0]      hold_sel_q;
  logic [2:0]      hold_f3_q;
  logic [XLEN-1:0] hold_alu_q, hold_pc4_q, hold_imm_q;

  logic [RD_W-1:0] src_rd;
  logic            src_rw, src_is_load;
  logic [1:0]      src_sel;
  logic [2:0]      src_f3;
  logic [XLEN-1:0] src_alu, src_pc4, src_imm;

  // In WAIT the live inputs are ignored and the held load is the source.
  always_comb begin
    src_rd      = in_rd;
    src_rw      = in_reg_write;
    src_is_load = in_is_load;
    src_sel     = in_wb_sel;
    src_f3      = in_funct3;
    src_alu     = in_alu_result;
    src_pc4     = in_pc_plus4;
    src_imm     = in_imm;
    if (state_q == StWait) begin
      src_rd      = hold_rd_q;
      src_rw      = hold_rw_q;
      src_is_load = 1'b1;
      src_sel     = hold_sel_q;
      src_f3      = hold_f3_q;
      src_alu     = hold_alu_q;
      src_pc4     = hold_pc4_q;
      src_imm     = hold_imm_q;
    end
  end

  logic [1:0]      off;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;

  assign off     = src_alu[1:0];
  assign ld_byte = dmem_rdata[{off, 3'b000} +: 8];
  assign ld_half = dmem_rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    case (src_f3)
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  logic take_run, go_wait, emit, rw_ok;

  assign take_run = (state_q == StRun) && in_valid;
  assign go_wait  = take_run && in_is_load && !dmem_rvalid;
  assign emit     = (take_run && (!in_is_load || dmem_rvalid)) ||
                    ((state_q == StWait) && dmem_rvalid);
  assign stall_o  = rst_n && (go_wait || ((state_q == StWait) && !dmem_rvalid));

`ifdef MEM_WB_MISALIGN_CHK_EN
  logic misalign;
  assign misalign = src_is_load && (((src_f3[1:0] == 2'b01) && off[0]) ||
                                    ((src_f3 == 3'b010) && (off != 2'b00)));
  assign rw_ok    = !misalign;
`else
  assign rw_ok    = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (go_wait) state_d = StWait;
      StWait:  if (dmem_rvalid) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StRun;
      hold_rd_q    <= '0;
      hold_rw_q    <= 1'b0;
      hold_sel_q   <= '0;
      hold_f3_q    <= '0;
      hold_alu_q   <= '0;
      hold_pc4_q   <= '0;
      hold_imm_q   <= '0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_sel       <= '0;
      wb_i0        <= '0;
      wb_i1        <= '0;
      wb_i2        <= '0;
      wb_i3        <= '0;
`ifdef MEM_WB_MISALIGN_CHK_EN
      wb_misalign  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wb_valid     <= emit;
      wb_reg_write <= emit && src_rw && rw_ok;
`ifdef MEM_WB_MISALIGN_CHK_EN
      wb_misalign  <= emit && misalign;
`endif
      if (go_wait) begin
        hold_rd_q  <= in_rd;
        hold_rw_q  <= in_reg_write;
        hold_sel_q <= in_wb_sel;
        hold_f3_q  <= in_funct3;
        hold_alu_q <= in_alu_result;
        hold_pc4_q <= in_pc_plus4;
        hold_imm_q <= in_imm;
      end
      // Data registers keep stale values across bubbles.
      if (emit) begin
        wb_rd  <= src_rd;
        wb_sel <= src_sel;
        wb_i0  <= src_alu;
        wb_i1  <= src_is_load ? ld_data : '0;
        wb_i2  <= src_pc4;
        wb_i3  <= src_imm;
      end
    end
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline stage of the RV32I core. Sits directly upstream of the writeback 4:1 select mux.
- Registers the four writeback candidates in mux order, together with the select, rd and reg_write: i0 = ALU result, i1 = formatted load data, i2 = PC+4, i3 = immediate.
- Aligns and sign/zero-extends load data from a data memory that may return data late.
- Stalls upstream through a two-state FSM until the load data arrives.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  MEM-stage instruction valid
- in_reg_write  input  1  instruction writes rd
- in_rd  input  RD_W  destination register
- in_wb_sel  input  2  writeback select (0 alu, 1 load, 2 pc+4, 3 imm)
- in_is_load  input  1  instruction is a load
- in_funct3  input  3  load type
- in_alu_result  input  XLEN  ALU result / load address
- in_pc_plus4  input  XLEN  PC+4
- in_imm  input  XLEN  immediate
- dmem_rdata  input  XLEN  raw word from data memory
- dmem_rvalid  input  1  dmem_rdata valid this cycle
- stall_o  output  1  hold MEM and earlier stages
- wb_valid  output  1  writeback slot valid
- wb_reg_write  output  1  reg_write qualified by wb_valid
- wb_rd  output  RD_W  destination register
- wb_sel  output  2  select for the writeback mux
- wb_i0  output  XLEN  ALU result
- wb_i1  output  XLEN  formatted load data
- wb_i2  output  XLEN  PC+4
- wb_i3  output  XLEN  immediate

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-low (rst_n sampled on the rising edge of clk). While rst_n = 0, all wb_* outputs are 0, the FSM is in RUN, and stall_o is 0.
- FSM has two states, RUN and WAIT.
- RUN, in_valid = 0: on the next edge wb_valid = 0 and wb_reg_write = 0 (bubble). wb data registers may hold stale values.
- RUN, in_valid and (!in_is_load or dmem_rvalid): capture all fields on the edge. Latency is 1 cycle. wb_i1 = formatted dmem_rdata for loads, 0 otherwise.
- RUN, in_valid, in_is_load and !dmem_rvalid:
  - Capture metadata (rd, reg_write, wb_sel, funct3, alu_result[1:0], pc_plus4, imm, alu_result) into a hold copy.
  - Go to WAIT.
  - Emit a bubble (wb_valid = 0).
- WAIT, !dmem_rvalid: stay in WAIT; outputs remain a bubble.
- WAIT, dmem_rvalid: on the edge, emit the held instruction with formatted data, set wb_valid = 1, and return to RUN.
- In WAIT, all in_* inputs are ignored.
- stall_o is combinational: (RUN and in_valid and in_is_load and !dmem_rvalid) or (WAIT and !dmem_rvalid). It deasserts in the same cycle dmem_rvalid arrives. Upstream holds in_* stable while stall_o = 1.
- dmem_rvalid with no load pending (RUN and not a valid load) is ignored.
- Load formatting uses offset = alu_result[1:0]:
  - LB (000): byte[offset], sign-extended.
  - LBU (100): byte[offset], zero-extended.
  - LH (001): half[offset[1]], sign-extended.
  - LHU (101): half[offset[1]], zero-extended.
  - LW (010) and any other funct3: full word.
- Misaligned halfword/word accesses ignore the low offset bit(s); there is no fault unless the optional feature is compiled in.
- Reset asserted in WAIT: returns to RUN next edge, the pending load is dropped, outputs are 0.

Optional Feature:
- Macro: MEM_WB_MISALIGN_CHK_EN.
- When defined:
  - Adds output port wb_misalign (1 bit).
  - wb_misalign is set for a load with LH/LHU and offset[0] = 1, or LW and offset != 0.
  - For such a load, wb_reg_write is forced to 0 while wb_valid = 1.
  - Reset value of wb_misalign is 0.
- When undefined: the port is absent and no check is performed.

Test Plan:
- Non-load: in_valid = 1, wb_sel = 0, alu = 0x0000_1234, rd = 5 -> next cycle wb_valid = 1, wb_reg_write = 1, wb_rd = 5, wb_i0 = 0x0000_1234, stall_o = 0 throughout.
- Same-cycle load: LB at alu = 0x...03, dmem_rdata = 0x80FF_FFFF, rvalid = 1 -> wb_i1 = 0xFFFF_FF80. Repeat with LBU -> wb_i1 = 0x0000_0080.
- Late load: LHU at offset 2, rvalid low for 3 cycles:
  - stall_o high for 3 cycles; wb_valid = 0 during them.
  - Then rdata = 0xBEEF_1234 with rvalid -> next cycle wb_i1 = 0x0000_BEEF, wb_valid = 1, FSM in RUN.
- Back-to-back: load, then ALU op, then load, each with immediate rvalid -> three consecutive wb_valid cycles with correct wb_sel 1, 0, 1 and no stall.
- Reset in WAIT: rst_n = 0 for one edge while waiting -> all outputs 0, stall_o = 0. A later rvalid produces no writeback.
- With MEM_WB_MISALIGN_CHK_EN: LW at alu = 0x...02 -> wb_misalign = 1, wb_valid = 1, wb_reg_write = 0.
